// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and the pixel/colour stage.
// No valid/ready: every clk carries exactly one raster position, and the consumer samples it unconditionally.
interface vga_timing_if;
    logic       mode;
    logic       o_hsync;
    logic       o_vsync;
    logic [9:0] o_hpos;
    logic [9:0] o_vpos;
    logic       o_hmax;
    logic       o_vmax;
    logic       o_hblank;
    logic       o_vblank;
    logic       o_visible;
    logic       o_mode;

    modport master (
        input  mode,
        output o_hsync, o_vsync, o_hpos, o_vpos, o_hmax, o_vmax,
        output o_hblank, o_vblank, o_visible, o_mode
    );

    modport slave (
        output mode,
        input  o_hsync, o_vsync, o_hpos, o_vpos, o_hmax, o_vmax,
        input  o_hblank, o_vblank, o_visible, o_mode
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Dual-mode VGA raster timing generator (640x480@60 / 640x480@72).
// Every output is a register loaded from the next raster position, so all flags describe the same pixel.
module vga_timing_gen #(
    parameter int H_VIS    = 640,
    parameter int V_VIS    = 480,
    parameter int H0_FP    = 16,
    parameter int H0_SY    = 96,
    parameter int H0_BP    = 48,
    parameter int V0_FP    = 10,
    parameter int V0_SY    = 2,
    parameter int V0_BP    = 33,
    parameter int H1_FP    = 24,
    parameter int H1_SY    = 40,
    parameter int H1_BP    = 128,
    parameter int V1_FP    = 9,
    parameter int V1_SY    = 3,
    parameter int V1_BP    = 28,
    parameter bit SYNC_POL = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    vga_timing_if.master vga
);

    localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
    localparam logic [9:0] H0_LAST  = 10'(H_VIS + H0_FP + H0_SY + H0_BP - 1);
    localparam logic [9:0] V0_LAST  = 10'(V_VIS + V0_FP + V0_SY + V0_BP - 1);
    localparam logic [9:0] H1_LAST  = 10'(H_VIS + H1_FP + H1_SY + H1_BP - 1);
    localparam logic [9:0] V1_LAST  = 10'(V_VIS + V1_FP + V1_SY + V1_BP - 1);
    localparam logic [9:0] HS0_BEG  = 10'(H_VIS + H0_FP);
    localparam logic [9:0] HS0_END  = 10'(H_VIS + H0_FP + H0_SY);
    localparam logic [9:0] VS0_BEG  = 10'(V_VIS + V0_FP);
    localparam logic [9:0] VS0_END  = 10'(V_VIS + V0_FP + V0_SY);
    localparam logic [9:0] HS1_BEG  = 10'(H_VIS + H1_FP);
    localparam logic [9:0] HS1_END  = 10'(H_VIS + H1_FP + H1_SY);
    localparam logic [9:0] VS1_BEG  = 10'(V_VIS + V1_FP);
    localparam logic [9:0] VS1_END  = 10'(V_VIS + V1_FP + V1_SY);

    logic [9:0] hpos_q, vpos_q;
    logic       hmax_q, vmax_q, hblank_q, vblank_q, visible_q;
    logic       hsync_q, vsync_q, mode_q;

    logic [9:0] hpos_d, vpos_d;
    logic       mode_d;
    logic       frame_end;
    logic [9:0] h_last, v_last, hs_beg, hs_end, vs_beg, vs_end;

    always_comb begin
        frame_end = hmax_q & vmax_q;
        // The requested mode is only taken on the frame-end edge, so a frame never mixes timings.
        mode_d    = frame_end ? vga.mode : mode_q;

        if (hmax_q) begin
            hpos_d = '0;
            vpos_d = vmax_q ? '0 : vpos_q + 10'd1;
        end else begin
            hpos_d = hpos_q + 10'd1;
            vpos_d = vpos_q;
        end

        h_last = mode_d ? H1_LAST : H0_LAST;
        v_last = mode_d ? V1_LAST : V0_LAST;
        hs_beg = mode_d ? HS1_BEG : HS0_BEG;
        hs_end = mode_d ? HS1_END : HS0_END;
        vs_beg = mode_d ? VS1_BEG : VS0_BEG;
        vs_end = mode_d ? VS1_END : VS0_END;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q    <= '0;
            vpos_q    <= '0;
            hmax_q    <= 1'b0;
            vmax_q    <= 1'b0;
            hblank_q  <= 1'b0;
            vblank_q  <= 1'b0;
            visible_q <= 1'b1;
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            mode_q    <= 1'b0;
        end else begin
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            mode_q    <= mode_d;
            hmax_q    <= (hpos_d == h_last);
            vmax_q    <= (vpos_d == v_last);
            hblank_q  <= (hpos_d >= H_VIS_W);
            vblank_q  <= (vpos_d >= V_VIS_W);
            visible_q <= (hpos_d < H_VIS_W) && (vpos_d < V_VIS_W);
            hsync_q   <= (hpos_d >= hs_beg && hpos_d < hs_end) ? SYNC_POL : ~SYNC_POL;
            // vpos only moves when hpos wraps to 0, which keeps vsync line-aligned.
            vsync_q   <= (vpos_d >= vs_beg && vpos_d < vs_end) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign vga.o_hpos    = hpos_q;
    assign vga.o_vpos    = vpos_q;
    assign vga.o_hmax    = hmax_q;
    assign vga.o_vmax    = vmax_q;
    assign vga.o_hblank  = hblank_q;
    assign vga.o_vblank  = vblank_q;
    assign vga.o_visible = visible_q;
    assign vga.o_hsync   = hsync_q;
    assign vga.o_vsync   = vsync_q;
    assign vga.o_mode    = mode_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for real 640x480 line timing and a
// shrunken instance so whole frames, mode latching and resets fit in a short run.
module tb_vga_timing_gen;

    localparam int S_HVIS = 16, S_VVIS = 8;
    localparam int S_H0FP = 2, S_H0SY = 4, S_H0BP = 3;
    localparam int S_V0FP = 2, S_V0SY = 1, S_V0BP = 3;
    localparam int S_H1FP = 3, S_H1SY = 2, S_H1BP = 5;
    localparam int S_V1FP = 1, S_V1SY = 2, S_V1BP = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    vga_timing_if if_f ();
    vga_timing_if if_s ();

    vga_timing_gen u_full (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_f)
    );

    vga_timing_gen #(
        .H_VIS(S_HVIS), .V_VIS(S_VVIS),
        .H0_FP(S_H0FP), .H0_SY(S_H0SY), .H0_BP(S_H0BP),
        .V0_FP(S_V0FP), .V0_SY(S_V0SY), .V0_BP(S_V0BP),
        .H1_FP(S_H1FP), .H1_SY(S_H1SY), .H1_BP(S_H1BP),
        .V1_FP(S_V1FP), .V1_SY(S_V1SY), .V1_BP(S_V1BP),
        .SYNC_POL(1'b0)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_s)
    );

    // Timing tables: index 0 = full-size instance, 1 = small instance; second index = mode.
    int hvis[2], vvis[2];
    int hfp[2][2], hsy[2][2], hbp[2][2];
    int vfp[2][2], vsy[2][2], vbp[2][2];

    // Reference model: cycles elapsed in the current frame plus the mode governing it.
    int t_el[2];
    int fmode[2];
    logic [27:0] exp_q_f[$];
    logic [27:0] exp_q_s[$];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int htot(int i, int m);
        return hvis[i] + hfp[i][m] + hsy[i][m] + hbp[i][m];
    endfunction

    function automatic int vtot(int i, int m);
        return vvis[i] + vfp[i][m] + vsy[i][m] + vbp[i][m];
    endfunction

    // {hsync, vsync, hpos, vpos, hmax, vmax, hblank, vblank, visible, mode}
    function automatic logic [27:0] model_vec(int i);
        int   m   = fmode[i];
        int   ht  = htot(i, m);
        int   h   = t_el[i] % ht;
        int   v   = t_el[i] / ht;
        int   hs0 = hvis[i] + hfp[i][m];
        int   vs0 = vvis[i] + vfp[i][m];
        logic hs  = !(h >= hs0 && h < hs0 + hsy[i][m]);
        logic vs  = !(v >= vs0 && v < vs0 + vsy[i][m]);
        logic hb  = (h >= hvis[i]);
        logic vb  = (v >= vvis[i]);
        logic [9:0] h10 = 10'(h);
        logic [9:0] v10 = 10'(v);
        logic mb  = (m != 0);
        return {hs, vs, h10, v10, (h == ht - 1), (v == vtot(i, m) - 1), hb, vb, !(hb || vb), mb};
    endfunction

    function automatic logic [27:0] dut_vec(int i);
        if (i == 0)
            return {if_f.o_hsync, if_f.o_vsync, if_f.o_hpos, if_f.o_vpos, if_f.o_hmax, if_f.o_vmax,
                    if_f.o_hblank, if_f.o_vblank, if_f.o_visible, if_f.o_mode};
        return {if_s.o_hsync, if_s.o_vsync, if_s.o_hpos, if_s.o_vpos, if_s.o_hmax, if_s.o_vmax,
                if_s.o_hblank, if_s.o_vblank, if_s.o_visible, if_s.o_mode};
    endfunction

    task automatic model_publish(input int i);
        if (i == 0) begin
            if (exp_q_f.size() > 0) void'(exp_q_f.pop_front());
            exp_q_f.push_back(model_vec(0));
        end else begin
            if (exp_q_s.size() > 0) void'(exp_q_s.pop_front());
            exp_q_s.push_back(model_vec(1));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            t_el[i]  = 0;
            fmode[i] = 0;
            model_publish(i);
        end
    endtask

    task automatic model_step(input int i, input logic mode_in);
        if (t_el[i] == htot(i, fmode[i]) * vtot(i, fmode[i]) - 1) begin
            t_el[i]  = 0;
            fmode[i] = int'(mode_in);
        end else begin
            t_el[i]++;
        end
        model_publish(i);
    endtask

    task automatic check_inst(input string p, input int i, input logic [27:0] d, input logic [27:0] e);
        int m = int'(d[0]);
        check_eq({p, ".pos"},   32'(d[25:6]),  32'(e[25:6]));
        check_eq({p, ".flags"}, 32'(d[5:1]),   32'(e[5:1]));
        check_eq({p, ".sync"},  32'(d[27:26]), 32'(e[27:26]));
        check_eq({p, ".mode"},  32'(d[0]),     32'(e[0]));
        check_eq({p, ".range"}, 32'((int'(d[25:16]) < htot(i, m)) && (int'(d[15:6]) < vtot(i, m))), 32'd1);
    endtask

    task automatic check_cycle();
        check_inst("f", 0, dut_vec(0), exp_q_f[0]);
        check_inst("s", 1, dut_vec(1), exp_q_s[0]);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step(0, if_f.mode);
            model_step(1, if_s.mode);
            @(negedge clk);
            check_cycle();
        end
    endtask

    task automatic wait_fe_s(input int budget);
        bit found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            run(1);
            if (if_s.o_hmax && if_s.o_vmax) found = 1'b1;
        end
        check_eq("s.fe_wait", 32'(found), 32'd1);
    endtask

    // Call while sitting on a frame-end cycle: measures the whole following frame.
    task automatic measure_s(input int m);
        int len = 0, vmax_cnt = 0, hs_cnt = 0, vs_cnt = 0, mode1_cnt = 0;
        bit done = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            run(1);
            len++;
            if (if_s.o_vmax)   vmax_cnt++;
            if (!if_s.o_hsync) hs_cnt++;
            if (!if_s.o_vsync) vs_cnt++;
            if (if_s.o_mode)   mode1_cnt++;
            if (if_s.o_hmax && if_s.o_vmax) done = 1'b1;
        end
        check_eq("s.frame_done", 32'(done), 32'd1);
        check_eq("s.frame_len",  32'(len), 32'(htot(1, m) * vtot(1, m)));
        check_eq("s.vmax_cnt",   32'(vmax_cnt), 32'(htot(1, m)));
        check_eq("s.hsync_cnt",  32'(hs_cnt), 32'(vtot(1, m) * hsy[1][m]));
        check_eq("s.vsync_cnt",  32'(vs_cnt), 32'(htot(1, m) * vsy[1][m]));
        check_eq("s.mode_cnt",   32'(mode1_cnt), 32'((m != 0) ? len : 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_cnt = 0, hs_first = -1, hmax_cnt = 0, vis_cnt = 0;
        bit found;

        hvis[0] = 640; vvis[0] = 480;
        hfp[0][0] = 16; hsy[0][0] = 96; hbp[0][0] = 48;
        vfp[0][0] = 10; vsy[0][0] = 2;  vbp[0][0] = 33;
        hfp[0][1] = 24; hsy[0][1] = 40; hbp[0][1] = 128;
        vfp[0][1] = 9;  vsy[0][1] = 3;  vbp[0][1] = 28;
        hvis[1] = S_HVIS; vvis[1] = S_VVIS;
        hfp[1][0] = S_H0FP; hsy[1][0] = S_H0SY; hbp[1][0] = S_H0BP;
        vfp[1][0] = S_V0FP; vsy[1][0] = S_V0SY; vbp[1][0] = S_V0BP;
        hfp[1][1] = S_H1FP; hsy[1][1] = S_H1SY; hbp[1][1] = S_H1BP;
        vfp[1][1] = S_V1FP; vsy[1][1] = S_V1SY; vbp[1][1] = S_V1BP;

        // Clock/reset
        if_f.mode = 1'b0;
        if_s.mode = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk); check_cycle();
        @(negedge clk); check_cycle();
        rst_n = 1'b1;

        // Two full-size lines in mode 0
        for (int k = 1; k <= 1600; k++) begin
            run(1);
            if (k == 1) check_eq("f.first_step", 32'(if_f.o_hpos), 32'd1);
            if (!if_f.o_hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(if_f.o_hpos);
            end
            if (if_f.o_hmax)    hmax_cnt++;
            if (if_f.o_visible) vis_cnt++;
        end
        check_eq("f.hsync_first", 32'(hs_first), 32'd656);
        check_eq("f.hsync_cnt",   32'(hs_cnt),   32'd192);
        check_eq("f.hmax_cnt",    32'(hmax_cnt), 32'd2);
        check_eq("f.visible_cnt", 32'(vis_cnt),  32'd1280);

        // Mode 0 frame on the small instance
        wait_fe_s(800);
        measure_s(0);

        // Request mode 1 mid-frame; it governs the frame after the next frame end
        run(40);
        if_s.mode = 1'b1;
        wait_fe_s(800);
        measure_s(1);

        // Back to mode 0, then 0->1->0 inside a frame must leave it at mode 0
        if_s.mode = 1'b0;
        wait_fe_s(800);
        run(50);
        if_s.mode = 1'b1;
        run(50);
        if_s.mode = 1'b0;
        wait_fe_s(800);
        measure_s(0);

        // Random mode requests every cycle on both instances
        for (int k = 0; k < 3000; k++) begin
            if_f.mode = 1'($urandom_range(0, 1));
            if_s.mode = 1'($urandom_range(0, 1));
            run(1);
        end

        // Async reset mid-frame with mode 1 in effect on the small instance
        if_f.mode = 1'b0;
        if_s.mode = 1'b1;
        wait_fe_s(800);
        run(5);
        check_eq("s.mode_before_rst", 32'(if_s.o_mode), 32'd1);
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            run(1);
            if (if_f.o_hpos == 10'd700) found = 1'b1;
        end
        check_eq("f.reach_700", 32'(found), 32'd1);
        @(posedge clk);
        model_step(0, if_f.mode);
        model_step(1, if_s.mode);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_cycle();
        @(negedge clk); check_cycle();
        rst_n = 1'b1;
        run(1);
        check_eq("f.resume_hpos",   32'(if_f.o_hpos), 32'd1);
        check_eq("s.mode_after_rst", 32'(if_s.o_mode), 32'd0);
        run(900);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
